multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter: EXC_CAUSE_UNDEF, default 2'b01, cause code for an undefined opcode.
REQ-002 Parameter: EXC_CAUSE_OVF, default 2'b10, cause code for arithmetic overflow.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports in this order:
- SYS_clk  in  1  clock
- SYS_reset  in  1  synchronous active-high reset
REQ-004 The block SHALL have these input ports:
- opcode  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0]
- alu_zero  in  1  ALU zero flag
- alu_ovf  in  1  ALU signed-overflow flag
- mem_ready  in  1  memory access completes this cycle
REQ-005 The block SHALL have these output ports:
- pc_write  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 branch target register, 10 jump address, 11 exception vector
- iord  out  1  memory address select: 0 PC, 1 ALU output register
- mem_read, mem_write, ir_write, reg_write  out  1 each  enables
- reg_dst  out  1  1 selects rd, 0 selects rt
- mem_to_reg  out  1  1 selects memory data register
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2
- alu_op  out  2  00 add, 01 subtract, 10 decode funct
- epc_write, cause_write  out  1 each  exception register enables
- cause  out  2  registered exception cause
- state  out  4  current state
- instr_count  out  16  count of retired instructions

Function
REQ-006 States and encodings SHALL be:
- FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6
- R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, EXC=12
- Codes 13-15 SHALL return to FETCH on the next clock.
REQ-007 Any output not listed for a state SHALL be 0.
REQ-008 FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=pc_write=mem_ready; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-009 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
- 0x00 -> EXEC_R
- 0x23 or 0x2B -> MEM_ADDR
- 0x04 -> BRANCH
- 0x02 -> JUMP
- 0x08 -> ADDI_EX
- any other opcode -> EXC, with cause loaded with EXC_CAUSE_UNDEF.
REQ-010 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEM_READ if opcode=0x23, else MEM_WRITE.
REQ-011 MEM_READ: iord=1, mem_read=1; wait until mem_ready=1, then go to MEM_WB.
REQ-012 MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1; go to FETCH.
REQ-013 MEM_WRITE: iord=1, mem_write=1; wait until mem_ready=1, then go to FETCH.
REQ-014 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. If alu_ovf=1 and funct is 0x20 or 0x22, go to EXC with cause loaded with EXC_CAUSE_OVF; otherwise go to R_WB.
REQ-015 R_WB: reg_dst=1, mem_to_reg=0, reg_write=1; go to FETCH.
REQ-016 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=alu_zero (combinational); go to FETCH.
REQ-017 JUMP: pc_src=10, pc_write=1; go to FETCH.
REQ-018 ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. If alu_ovf=1, go to EXC with cause loaded with EXC_CAUSE_OVF; otherwise go to ADDI_WB.
REQ-019 ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1; go to FETCH.
REQ-020 EXC: epc_write=1, cause_write=1, pc_src=11, pc_write=1; go to FETCH. reg_write and mem_write SHALL never assert for the faulting instruction.
REQ-021 cause SHALL change only on entry to EXC and hold its value otherwise.
REQ-022 Latency with mem_ready tied high SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4, exception 3 (undefined opcode) or 4 (overflow), counted from entry to FETCH through return to FETCH.
REQ-023 instr_count SHALL increment by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, or ADDI_WB, wrapping 0xFFFF -> 0x0000. It SHALL NOT increment on exit from EXC.
REQ-024 mem_read and mem_write SHALL never be 1 in the same cycle. pc_write SHALL be 1 for at most one cycle per instruction.

Reset
REQ-025 While SYS_reset=1 at a clock edge: state SHALL become FETCH, cause 2'b00, instr_count 0.
REQ-026 While SYS_reset=1, all enable outputs (pc_write, mem_read, mem_write, ir_write, reg_write, epc_write, cause_write) SHALL be forced to 0.
REQ-027 Reset during any wait state (FETCH, MEM_READ, MEM_WRITE) SHALL abandon the access, with no write or retire count.

Verification
REQ-028 mem_ready=1, opcode=0x00, funct=0x20, alu_ovf=0 -> states 0,1,6,7,0; reg_write=1 with reg_dst=1 only in state 7; instr_count goes 0 -> 1.
REQ-029 opcode=0x23, mem_ready low for 3 cycles in MEM_READ -> state held at 3 for 3 cycles with mem_read=1, iord=1; then 4,0; total 8 cycles.
REQ-030 opcode=0x04: with alu_zero=1, pc_write=1 and pc_src=01 in state 8; with alu_zero=0, pc_write=0 in state 8; both cases increment instr_count.
REQ-031 opcode=0x3F -> states 0,1,12,0; cause=01, epc_write=cause_write=pc_write=1, pc_src=11 in state 12; instr_count unchanged.
REQ-032 opcode=0x08 with alu_ovf=1 in state 10 -> state 12, cause=10, no reg_write. Separately, instr_count preset to 0xFFFF plus one j instruction -> instr_count wraps to 0x0000.
REQ-033 SYS_reset=1 asserted in MEM_WRITE with mem_ready=0 -> next state 0, mem_write=0 during reset, instr_count=0, cause=00.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control FSM: sequences fetch/decode/execute/memory/writeback,
// keeps a registered exception cause and a count of retired instructions.
module multi_cycle_ctrl #(
    parameter logic [1:0] EXC_CAUSE_UNDEF = 2'b01,
    parameter logic [1:0] EXC_CAUSE_OVF   = 2'b10
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        epc_write,
    output logic        cause_write,
    output logic [1:0]  cause,
    output logic [3:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_READ = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WRITE= 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_EXC      = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    state_e      state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic        retire;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cause_d     = cause_q;
        retire      = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        epc_write   = 1'b0;
        cause_write = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        state_d = S_EXC;
                        cause_d = EXC_CAUSE_UNDEF;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                // Only signed add/sub trap on overflow; addu/subu and logic ops never do.
                if (alu_ovf && (funct == FN_ADD || funct == FN_SUB)) begin
                    state_d = S_EXC;
                    cause_d = EXC_CAUSE_OVF;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_write  = alu_zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (alu_ovf) begin
                    state_d = S_EXC;
                    cause_d = EXC_CAUSE_OVF;
                end else begin
                    state_d = S_ADDI_WB;
                end
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXC: begin
                epc_write   = 1'b1;
                cause_write = 1'b1;
                pc_src      = 2'b11;
                pc_write    = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        instr_count_d = retire ? instr_count_q + 16'd1 : instr_count_q;

        // Abandon any in-flight access while reset is held.
        if (SYS_reset) begin
            pc_write    = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            epc_write   = 1'b0;
            cause_write = 1'b0;
        end
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q       <= S_FETCH;
            cause_q       <= 2'b00;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign cause       = cause_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: per-instruction state paths from a reference
// model, checked each cycle with directed, randomized, wrap and reset-abort scenarios.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        sys_reset;
    logic [5:0]  opcode, funct;
    logic        alu_zero, alu_ovf, mem_ready;
    logic        pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic        reg_dst, mem_to_reg, alu_src_a, epc_write, cause_write;
    logic [1:0]  pc_src, alu_src_b, alu_op, cause;
    logic [3:0]  state;
    logic [15:0] instr_count;
    logic [16:0] ctrl;

    int          tests = 0;
    int          fails = 0;
    logic [1:0]  m_cause;
    logic [15:0] m_count;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .SYS_clk     (clk),
        .SYS_reset   (sys_reset),
        .opcode      (opcode),
        .funct       (funct),
        .alu_zero    (alu_zero),
        .alu_ovf     (alu_ovf),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .epc_write   (epc_write),
        .cause_write (cause_write),
        .cause       (cause),
        .state       (state),
        .instr_count (instr_count)
    );

    assign ctrl = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
                   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, epc_write, cause_write};

    // Control word each state should present, straight from the state output table.
    function automatic logic [16:0] exp_ctrl(input int s, input logic mr, input logic z, input logic r);
        logic pcw, io, mrd, mwr, irw, rw, rdst, m2r, sa, ew, cw;
        logic [1:0] psrc, sb, op;
        {pcw, io, mrd, mwr, irw, rw, rdst, m2r, sa, ew, cw} = '0;
        psrc = 2'b00;
        sb   = 2'b00;
        op   = 2'b00;
        case (s)
            0:  begin mrd = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1'b1; sb = 2'b10; end
            3:  begin io = 1'b1; mrd = 1'b1; end
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin io = 1'b1; mwr = 1'b1; end
            6:  begin sa = 1'b1; op = 2'b10; end
            7:  begin rdst = 1'b1; rw = 1'b1; end
            8:  begin sa = 1'b1; op = 2'b01; psrc = 2'b01; pcw = z; end
            9:  begin psrc = 2'b10; pcw = 1'b1; end
            10: begin sa = 1'b1; sb = 2'b10; end
            11: rw = 1'b1;
            12: begin ew = 1'b1; cw = 1'b1; psrc = 2'b11; pcw = 1'b1; end
            default: ;
        endcase
        if (r) {pcw, mrd, mwr, irw, rw, ew, cw} = '0;
        return {pcw, psrc, io, mrd, mwr, irw, rw, rdst, m2r, sa, sb, op, ew, cw};
    endfunction

    task automatic check_cycle(input int es);
        logic [16:0] ec;
        @(negedge clk);
        ec = exp_ctrl(es, mem_ready, alu_zero, sys_reset);
        tests++;
        assert (state === 4'(es)) else begin
            fails++; $error("FAIL state: got %0d expected %0d", state, es);
        end
        tests++;
        assert (ctrl === ec) else begin
            fails++; $error("FAIL ctrl(st%0d): got %05h expected %05h", es, ctrl, ec);
        end
        tests++;
        assert (cause === m_cause) else begin
            fails++; $error("FAIL cause: got %0h expected %0h", cause, m_cause);
        end
        tests++;
        assert (instr_count === m_count) else begin
            fails++; $error("FAIL instr_count: got %0h expected %0h", instr_count, m_count);
        end
        tests++;
        assert ((mem_read & mem_write) === 1'b0) else begin
            fails++; $error("FAIL rd_wr_excl: got %0b expected 0", mem_read & mem_write);
        end
        @(posedge clk);
        #1;
    endtask

    // rd_stalls < 0: random stalls everywhere; otherwise FETCH never stalls and each
    // memory wait stalls exactly rd_stalls cycles. abort_idx >= 0 resets at that path step.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                             input logic z, input int rd_stalls, input int abort_idx);
        int path[$];
        logic [1:0] code;
        code = 2'b01;
        case (op)
            6'h00: if (ovf && (fn == 6'h20 || fn == 6'h22)) begin
                       path = '{0, 1, 6, 12}; code = 2'b10;
                   end else path = '{0, 1, 6, 7};
            6'h23: path = '{0, 1, 2, 3, 4};
            6'h2B: path = '{0, 1, 2, 5};
            6'h04: path = '{0, 1, 8};
            6'h02: path = '{0, 1, 9};
            6'h08: if (ovf) begin
                       path = '{0, 1, 10, 12}; code = 2'b10;
                   end else path = '{0, 1, 10, 11};
            default: path = '{0, 1, 12};
        endcase
        opcode   = op;
        funct    = fn;
        alu_ovf  = ovf;
        alu_zero = z;
        foreach (path[i]) begin
            int s;
            bit wait_st;
            s = path[i];
            wait_st = (s == 0 || s == 3 || s == 5);
            if (i == abort_idx) begin
                sys_reset = 1'b1;
                mem_ready = 1'b0;
                check_cycle(s);
                sys_reset = 1'b0;
                m_count   = '0;
                m_cause   = '0;
                return;
            end
            if (s == 12) m_cause = code;
            if (wait_st) begin
                int n;
                if (rd_stalls < 0) n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                else               n = (s == 0) ? 0 : rd_stalls;
                repeat (n) begin
                    mem_ready = 1'b0;
                    check_cycle(s);
                end
            end
            mem_ready = wait_st ? 1'b1 : 1'($urandom & 1);
            check_cycle(s);
        end
        if (path[path.size()-1] != 12) m_count++;
    endtask

    initial begin
        sys_reset = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h00;
        alu_zero  = 1'b0;
        alu_ovf   = 1'b0;
        mem_ready = 1'b1;
        m_cause   = 2'b00;
        m_count   = 16'h0000;
        @(posedge clk);
        #1;
        check_cycle(0);
        sys_reset = 1'b0;

        // Directed: one of each instruction class and each trap.
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, -1);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 3, -1);
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 0, -1);
        run_instr(6'h04, 6'h00, 1'b0, 1'b1, 0, -1);
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, 0, -1);
        run_instr(6'h02, 6'h00, 1'b0, 1'b0, 0, -1);
        run_instr(6'h08, 6'h00, 1'b0, 1'b0, 0, -1);
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 0, -1);
        run_instr(6'h08, 6'h00, 1'b1, 1'b0, 0, -1);
        run_instr(6'h00, 6'h22, 1'b1, 1'b0, 0, -1);
        run_instr(6'h00, 6'h24, 1'b1, 1'b0, 0, -1);
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 2, -1);

        for (int k = 0; k < 300; k++) begin
            logic [5:0] op, fn;
            case ($urandom_range(0, 6))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'h02;
                5: op = 6'h08;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: fn = 6'h20;
                1: fn = 6'h22;
                default: fn = 6'($urandom);
            endcase
            run_instr(op, fn, ($urandom_range(0, 3) == 0), 1'($urandom & 1), -1, -1);
        end

        // Reset while MEM_WRITE waits: no write, count and cause cleared.
        run_instr(6'h00, 6'h20, 1'b1, 1'b0, 0, -1);
        run_instr(6'h02, 6'h00, 1'b0, 1'b0, 0, -1);
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 0, 3);
        run_instr(6'h02, 6'h00, 1'b0, 1'b0, 0, -1);

        // Counter wrap: preset to 0xFFFF while FETCH stalls, then retire one jump.
        mem_ready = 1'b0;
        force dut.instr_count_q = 16'hFFFF;
        #1 release dut.instr_count_q;
        m_count = 16'hFFFF;
        check_cycle(0);
        run_instr(6'h02, 6'h00, 1'b0, 1'b0, 0, -1);

        // Reset during FETCH and during MEM_READ.
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 0, -1);
        run_instr(6'h04, 6'h00, 1'b0, 1'b1, 0, 0);
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, -1);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, 3);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 1, -1);

        mem_ready = 1'b0;
        check_cycle(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
